data_recorder_seq: RTL and testbench

// - Autonomous bus-master sequencer for one data_recorder instance: soft-resets it, polls its ID constant,

---
 rtl/data_recorder_seq_pkg.sv | 13 +
 rtl/data_recorder_seq_rr_pick.sv | 40 ++++
 rtl/data_recorder_seq.sv | 186 ++++++++++++++++++
 tb/tb_data_recorder_seq.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_recorder_seq_pkg.sv
// Shared constants for the data_recorder playback sequencer.
// Register word offsets and the ID constant match the controlled data_recorder's register map.
package data_recorder_seq_pkg;

    localparam logic [31:0] SOFT_RESETN_ADDR         = 32'h0000_0000;
    localparam logic [31:0] DATA_RECORDER_CONST_ADDR = 32'h0000_0001;
    localparam logic [31:0] BUS_CHAN_ADDR            = 32'h0000_0002;
    localparam logic [31:0] RD_DEPTH_ADDR            = 32'h0000_0003;
    localparam logic [31:0] RD_START_ADDR            = 32'h0000_0004;

    localparam logic [31:0] DATA_RECORDER_CONST      = 32'hDA7A_0C0D;

endpackage

// File: rtl/data_recorder_seq_rr_pick.sv
// Round-robin channel picker: lowest enabled channel above idx, optionally wrapping to the
// lowest enabled channel overall (which may be idx itself).
module data_recorder_seq_rr_pick #(
    parameter int unsigned NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0]         mask,
    input  logic [$clog2(NUM_PORTS)-1:0] idx,
    input  logic                         wrap,
    output logic                         found,
    output logic [$clog2(NUM_PORTS)-1:0] chan
);

    localparam int unsigned CW = $clog2(NUM_PORTS);

    logic          hi_found;
    logic          lo_found;
    logic [CW-1:0] hi_chan;
    logic [CW-1:0] lo_chan;

    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_chan  = '0;
        lo_chan  = '0;
        // Scan downwards so the last hit is the lowest index.
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                hi_found = 1'b1;
                hi_chan  = CW'(i);
            end
            if (mask[i]) begin
                lo_found = 1'b1;
                lo_chan  = CW'(i);
            end
        end
        found = hi_found | (wrap & lo_found);
        chan  = hi_found ? hi_chan : lo_chan;
    end

endmodule

// File: rtl/data_recorder_seq.sv
// Autonomous bus master for one data_recorder: soft reset, ID poll, then round-robin playback
// of the enabled channels (select, depth, start, dwell, stop).
module data_recorder_seq
    import data_recorder_seq_pkg::*;
#(
    parameter int unsigned               BUS_ADDR_WIDTH = 32,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1480_0000,
    parameter int unsigned               NUM_PORTS      = 4,
    parameter int unsigned               DEPTH_WIDTH    = 16,
    parameter int unsigned               DWELL_WIDTH    = 24,
    parameter int unsigned               RD_LAT         = 2,
    parameter int unsigned               POLL_MAX       = 64
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         stop,
    input  logic [NUM_PORTS-1:0]         chan_mask,
    input  logic [DEPTH_WIDTH-1:0]       depth,
    input  logic [DWELL_WIDTH-1:0]       dwell,
    input  logic                         loop,
    output logic [BUS_ADDR_WIDTH-1:0]    bus_addr,
    output logic [31:0]                  bus_wdata,
    output logic                         bus_wr,
    output logic                         bus_rd,
    input  logic [31:0]                  bus_rdata,
    output logic                         busy,
    output logic [$clog2(NUM_PORTS)-1:0] cur_chan,
    output logic                         done,
    output logic                         error
);

    localparam int unsigned CW = $clog2(NUM_PORTS);
    localparam int unsigned TW = $clog2(POLL_MAX + 1);
    localparam int unsigned LW = $clog2(RD_LAT + 1);

    localparam logic [BUS_ADDR_WIDTH-1:0] A_SRST  = BASE_ADDR + BUS_ADDR_WIDTH'(SOFT_RESETN_ADDR);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_CONST =
        BASE_ADDR + BUS_ADDR_WIDTH'(DATA_RECORDER_CONST_ADDR);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_CHAN  = BASE_ADDR + BUS_ADDR_WIDTH'(BUS_CHAN_ADDR);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_DEPTH = BASE_ADDR + BUS_ADDR_WIDTH'(RD_DEPTH_ADDR);
    localparam logic [BUS_ADDR_WIDTH-1:0] A_START = BASE_ADDR + BUS_ADDR_WIDTH'(RD_START_ADDR);

    typedef enum logic [3:0] {
        StIdle, StSrst, StPoll, StPwait, StScan, StSel,
        StDepth, StGo, StDwell, StHalt, StDone, StErr
    } state_e;

    state_e                    state_q, state_d;
    logic [NUM_PORTS-1:0]      mask_q;
    logic [DEPTH_WIDTH-1:0]    depth_q;
    logic [DWELL_WIDTH-1:0]    dwell_q;
    logic                      loop_q;
    logic                      stop_q;
    logic                      first_q;
    logic [TW-1:0]             tries_q;
    logic [LW-1:0]             lat_q;
    logic [DWELL_WIDTH-1:0]    dwell_cnt_q;
    logic [CW-1:0]             cur_chan_q;
    logic                      error_q;
    logic [BUS_ADDR_WIDTH-1:0] addr_q, addr_now;
    logic [31:0]               wdata_q, wdata_now;

    logic                      accept;
    logic                      stop_eff;
    logic [DWELL_WIDTH-1:0]    dwell_eff;
    logic                      pick_found;
    logic [CW-1:0]             pick_chan;
    logic [CW-1:0]             pick_idx;

    assign accept    = (state_q == StIdle) && start && !stop;
    assign stop_eff  = stop_q | stop;
    assign dwell_eff = (dwell_q == '0) ? DWELL_WIDTH'(1) : dwell_q;
    // First pick of a run searches from the top with wrap, i.e. yields the lowest enabled channel.
    assign pick_idx  = first_q ? CW'(NUM_PORTS - 1) : cur_chan_q;

    data_recorder_seq_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .mask  (mask_q),
        .idx   (pick_idx),
        .wrap  (loop_q | first_q),
        .found (pick_found),
        .chan  (pick_chan)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StSrst;
            StSrst:  state_d = stop_eff ? StDone : StPoll;
            StPoll:  state_d = StPwait;
            StPwait: begin
                if (lat_q == LW'(RD_LAT)) begin
                    if (stop_eff)                              state_d = StDone;
                    else if (bus_rdata == DATA_RECORDER_CONST) state_d = StScan;
                    else if (tries_q >= TW'(POLL_MAX))         state_d = StErr;
                    else                                       state_d = StPoll;
                end
            end
            StScan:  state_d = (stop_eff || !pick_found) ? StDone : StSel;
            StSel:   state_d = stop_eff ? StDone : StDepth;
            StDepth: state_d = stop_eff ? StDone : StGo;
            // Once RD_START=1 is written, always pass through HALT before finishing.
            StGo:    state_d = StDwell;
            StDwell: if (stop_eff || (dwell_cnt_q >= dwell_eff)) state_d = StHalt;
            StHalt:  state_d = stop_eff ? StDone : StScan;
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus_wr    = 1'b0;
        bus_rd    = 1'b0;
        addr_now  = addr_q;
        wdata_now = wdata_q;
        unique case (state_q)
            StSrst:  begin bus_wr = 1'b1; addr_now = A_SRST;  wdata_now = 32'd1; end
            StPoll:  begin bus_rd = 1'b1; addr_now = A_CONST; end
            StSel:   begin bus_wr = 1'b1; addr_now = A_CHAN;  wdata_now = 32'(cur_chan_q); end
            StDepth: begin bus_wr = 1'b1; addr_now = A_DEPTH; wdata_now = 32'(depth_q); end
            StGo:    begin bus_wr = 1'b1; addr_now = A_START; wdata_now = 32'd1; end
            StHalt:  begin bus_wr = 1'b1; addr_now = A_START; wdata_now = 32'd0; end
            default: ;
        endcase
        bus_addr  = addr_now;
        bus_wdata = wdata_now;
        busy      = (state_q != StIdle);
        done      = (state_q == StDone) || (state_q == StErr);
        cur_chan  = cur_chan_q;
        error     = error_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mask_q      <= '0;
            depth_q     <= '0;
            dwell_q     <= '0;
            loop_q      <= 1'b0;
            stop_q      <= 1'b0;
            first_q     <= 1'b0;
            tries_q     <= '0;
            lat_q       <= '0;
            dwell_cnt_q <= '0;
            cur_chan_q  <= '0;
            error_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            if (accept) begin
                mask_q  <= chan_mask;
                depth_q <= depth;
                dwell_q <= dwell;
                loop_q  <= loop;
                first_q <= 1'b1;
                tries_q <= '0;
                error_q <= 1'b0;
            end else if (state_d == StErr) begin
                error_q <= 1'b1;
            end
            stop_q <= (accept || state_d == StIdle) ? 1'b0 : (stop_q | stop);
            if (state_q == StPoll) tries_q <= tries_q + TW'(1);
            if (state_q == StPoll)       lat_q <= LW'(1);
            else if (state_q == StPwait) lat_q <= lat_q + LW'(1);
            if (state_q == StGo)         dwell_cnt_q <= DWELL_WIDTH'(1);
            else if (state_q == StDwell) dwell_cnt_q <= dwell_cnt_q + DWELL_WIDTH'(1);
            if (state_q == StScan && state_d == StSel) begin
                cur_chan_q <= pick_chan;
                first_q    <= 1'b0;
            end
            if (bus_wr || bus_rd) addr_q  <= addr_now;
            if (bus_wr)           wdata_q <= wdata_now;
        end
    end

endmodule

// File: tb/tb_data_recorder_seq.sv
// Bench for data_recorder_seq: a per-cycle expected trace built from the sequencing rules,
// a simple recorder bus responder, and directed scenarios with literal pins.
module tb_data_recorder_seq;
    import data_recorder_seq_pkg::*;

    localparam int unsigned RDL  = 2;
    localparam int unsigned PMAX = 12;
    localparam logic [31:0] BASE = 32'h1480_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        loop = 1'b0;
    logic [3:0]  chan_mask = '0;
    logic [15:0] depth = '0;
    logic [23:0] dwell = '0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_wr, bus_rd, busy, done, error;
    logic [1:0]  cur_chan;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_recorder_seq #(
        .POLL_MAX (PMAX)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .stop      (stop),
        .chan_mask (chan_mask),
        .depth     (depth),
        .dwell     (dwell),
        .loop      (loop),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_wr    (bus_wr),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata),
        .busy      (busy),
        .cur_chan  (cur_chan),
        .done      (done),
        .error     (error)
    );

    // Recorder responder: the first hold_n reads of a run return 0 (recorder held in reset).
    int unsigned rd_total = 0;
    int unsigned rd_base = 0;
    int unsigned hold_n = 0;
    logic [1:0]  rv = '0;
    logic [31:0] rdat0 = '0;
    logic [31:0] rdat1 = '0;

    always @(posedge clk) begin
        if (bus_rd) rd_total <= rd_total + 1;
        rv    <= {rv[0], bus_rd};
        rdat0 <= (rd_total - rd_base < hold_n) ? 32'h0 : DATA_RECORDER_CONST;
        rdat1 <= rdat0;
    end
    assign bus_rdata = rv[1] ? rdat1 : 32'h0;

    typedef struct {
        logic        wr, rd, busy, done, err, cc;
        logic [31:0] addr, wdata;
        logic [1:0]  chan;
    } exp_t;

    exp_t exp_q[$];
    logic model_err = 1'b0;
    int   n_ent = 0;

    task automatic put(input logic wr, rd, input logic [31:0] off, wd, input logic dn, bz, cc,
                       input int ch);
        exp_t e;
        e.wr = wr; e.rd = rd; e.addr = BASE + off; e.wdata = wd;
        e.done = dn; e.busy = bz; e.cc = cc; e.chan = 2'(ch); e.err = model_err;
        exp_q.push_back(e);
        n_ent++;
    endtask

    function automatic int pick(input logic [3:0] m, input int last, input bit wrapok);
        for (int i = last + 1; i < 4; i++) if (m[i]) return i;
        if (wrapok) for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    // Expected outputs for every cycle from the start-pulse cycle to the done pulse.
    task automatic build(input logic [3:0] m, input int dp, dw, input bit lp, input int hold,
                         input int stop_idx);
        int  tries = 0;
        bit  ok = 0;
        int  last = -1;
        bit  first = 1;
        bit  stopped = 0;
        int  c;
        n_ent = 0;
        put(0, 0, 0, 0, 0, 0, 0, 0);
        model_err = 1'b0;
        put(1, 0, SOFT_RESETN_ADDR, 1, 0, 1, 0, 0);
        while (!ok && tries < int'(PMAX)) begin
            put(0, 1, DATA_RECORDER_CONST_ADDR, 0, 0, 1, 0, 0);
            repeat (RDL) put(0, 0, 0, 0, 0, 1, 0, 0);
            ok = (tries >= hold);
            tries++;
        end
        if (!ok) begin
            model_err = 1'b1;
            put(0, 0, 0, 0, 1, 1, 0, 0);
            return;
        end
        while (1) begin
            put(0, 0, 0, 0, 0, 1, 0, 0);
            c = pick(m, last, lp || first);
            if (c < 0) break;
            put(1, 0, BUS_CHAN_ADDR, 32'(c), 0, 1, 1, c);
            put(1, 0, RD_DEPTH_ADDR, 32'(dp), 0, 1, 1, c);
            put(1, 0, RD_START_ADDR, 1, 0, 1, 1, c);
            for (int j = 0; j < ((dw == 0) ? 1 : dw); j++) begin
                if (n_ent == stop_idx) stopped = 1;
                put(0, 0, 0, 0, 0, 1, 1, c);
                if (stopped) break;
            end
            put(1, 0, RD_START_ADDR, 0, 0, 1, 1, c);
            last = c;
            first = 0;
            if (stopped) break;
        end
        put(0, 0, 0, 0, 1, 1, 0, 0);
    endtask

    function automatic int count_wr();
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].wr) n++;
        return n;
    endfunction

    exp_t ce;
    int   cyc = 0;
    always @(negedge clk) begin
        cyc++;
        if (resetn && exp_q.size() > 0) begin
            ce = exp_q.pop_front();
            checks++;
            if (bus_wr !== ce.wr || bus_rd !== ce.rd || busy !== ce.busy || done !== ce.done ||
                error !== ce.err || ((ce.wr || ce.rd) && bus_addr !== ce.addr) ||
                (ce.wr && bus_wdata !== ce.wdata) || (ce.cc && cur_chan !== ce.chan)) begin
                errors++;
                $display("FAIL cycle %0d: got wr=%b rd=%b addr=%h wdata=%h busy=%b done=%b err=%b chan=%0d; want wr=%b rd=%b addr=%h wdata=%h busy=%b done=%b err=%b chan=%0d",
                         cyc, bus_wr, bus_rd, bus_addr, bus_wdata, busy, done, error, cur_chan,
                         ce.wr, ce.rd, ce.addr, ce.wdata, ce.busy, ce.done, ce.err, ce.chan);
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    // Called at posedge+1 of the start cycle (index 0).
    task automatic launch(input logic [3:0] m, input int dp, dw, input bit lp, input int hold,
                          input int stop_idx, restart_idx);
        int last_idx = 1;
        if (stop_idx > last_idx) last_idx = stop_idx;
        if (restart_idx > last_idx) last_idx = restart_idx;
        chan_mask = m; depth = 16'(dp); dwell = 24'(dw); loop = lp;
        hold_n = hold; rd_base = rd_total;
        start = 1'b1;
        for (int c = 1; c <= last_idx; c++) begin
            @(posedge clk); #1;
            start = (c == restart_idx);
            stop  = (c == stop_idx);
        end
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() > 0 && g < 4000) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d entries left want 0", exp_q.size());
            exp_q.delete();
        end
        #1;
    endtask

    task automatic go(input logic [3:0] m, input int dp, dw, input bit lp, input int hold,
                      input int stop_idx, restart_idx);
        @(posedge clk); #1;
        build(m, dp, dw, lp, hold, stop_idx);
        launch(m, dp, dw, lp, hold, stop_idx, restart_idx);
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({bus_wr, bus_rd, busy, done, error, cur_chan}), 0);
        chk("rst_addr", 64'(bus_addr), 0);
        chk("rst_wdata", 64'(bus_wdata), 0);
        @(negedge clk) resetn = 1'b1;

        // Two channels, single pass.
        @(posedge clk); #1;
        build(4'b0101, 8, 20, 0, 0, -1);
        chk("pin_len_a", 64'(exp_q.size()), 57);
        chk("pin_wr_a", 64'(count_wr()), 9);
        launch(4'b0101, 8, 20, 0, 0, -1, -1);
        drain();
        chk("a_busy_after", 64'(busy), 0);

        // Recorder answers only from the 11th poll.
        go(4'b0010, 3, 4, 0, 10, -1, -1);
        chk("hold10_reads", 64'(rd_total - rd_base), 11);
        chk("hold10_error", 64'(error), 0);

        // Recorder never answers: exactly PMAX reads then error.
        @(posedge clk); #1;
        build(4'b1111, 1, 1, 0, 1000, -1);
        chk("pin_len_err", 64'(exp_q.size()), 39);
        launch(4'b1111, 1, 1, 0, 1000, -1, -1);
        drain();
        chk("err_reads", 64'(rd_total - rd_base), 12);
        chk("err_sticky", 64'(error), 1);

        // Empty mask plus a start pulse while busy that must be ignored.
        @(posedge clk); #1;
        build(4'b0000, 5, 5, 0, 0, -1);
        chk("pin_len_empty", 64'(exp_q.size()), 7);
        launch(4'b0000, 5, 5, 0, 0, -1, 2);
        drain();
        chk("empty_reads", 64'(rd_total - rd_base), 1);
        chk("empty_err_cleared", 64'(error), 0);

        // start and stop together in IDLE: no run.
        @(posedge clk); #1;
        start = 1'b1; stop = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("startstop_busy", 64'({busy, bus_wr, bus_rd}), 0);

        // Looping single channel, stop in the 3rd dwell cycle of the 3rd pass.
        @(posedge clk); #1;
        build(4'b1000, 2, 5, 1, 0, 31);
        chk("pin_len_loop", 64'(exp_q.size()), 34);
        chk("pin_wr_loop", 64'(count_wr()), 13);
        launch(4'b1000, 2, 5, 1, 0, 31, -1);
        drain();
        chk("loop_busy_after", 64'(busy), 0);

        // Asynchronous reset in the middle of a dwell.
        @(posedge clk); #1;
        build(4'b0101, 8, 20, 0, 0, -1);
        launch(4'b0101, 8, 20, 0, 0, -1, -1);
        repeat (12) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy), 1);
        resetn = 1'b0;
        #1;
        exp_q.delete();
        chk("async_rst_strobes", 64'({bus_wr, bus_rd, busy}), 0);
        model_err = 1'b0;
        @(negedge clk) resetn = 1'b1;
        go(4'b0101, 8, 20, 0, 0, -1, -1);
        chk("post_rst_busy", 64'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
